// File: rtl/acc_diff_decimator.sv
// acc_diff_decimator: comb/differentiator end of an integrator path.
// Keeps every RATE-th accepted sample of a modular running sum and emits
// the wrapped difference against the previously kept sample (block sum).
module acc_diff_decimator #(
  parameter int WIDTH = 8,
  parameter int RATE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic [3:0]       phase
);

  typedef enum logic {PRIME, RUN} state_t;

  localparam logic [3:0] LAST_PHASE = 4'(RATE - 1);

  // Modular difference; the borrow falls off the top so accumulator
  // wrap-around between kept samples cancels out.
  function automatic logic signed [WIDTH-1:0] wrap_diff(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    return a - b;
  endfunction

  state_t                  state_q;
  state_t                  state_d;
  logic [3:0]              phase_q;
  logic signed [WIDTH-1:0] x_prev;
  logic signed [WIDTH-1:0] y_p1;
  logic                    vld_p1;
  logic                    keep;
  logic                    emit;

  assign keep = in_valid && (phase_q == LAST_PHASE);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the first keep after reset only establishes the reference
  always_comb begin
    state_d = state_q;
    if (state_q == PRIME && keep) begin
      state_d = RUN;
    end
  end

  // Output decode: a block sum is produced only once a reference exists
  always_comb begin
    emit = 1'b0;
    if (state_q == RUN && keep) begin
      emit = 1'b1;
    end
  end

  // Accepted-sample counter, frozen while in_valid is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= 4'd0;
    end else if (in_valid) begin
      phase_q <= (phase_q == LAST_PHASE) ? 4'd0 : phase_q + 4'd1;
    end
  end

  // Stage p1: reference capture, block-sum register and its valid pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_prev <= '0;
      y_p1   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= emit;
      if (keep) begin
        x_prev <= $signed(x);
      end
      if (emit) begin
        y_p1 <= wrap_diff($signed(x), x_prev);
      end
    end
  end

  assign y       = y_p1;
  assign y_valid = vld_p1;
  assign phase   = phase_q;

endmodule

// File: tb/tb_acc_diff_decimator.sv
// Directed bench for acc_diff_decimator: RATE=4 instance for the directed
// vectors, RATE=2 and RATE=16 instances for the randomized-increment sweep.
module tb_acc_diff_decimator;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] x;
  logic [7:0] y4, y2, y16;
  logic       yv4, yv2, yv16;
  logic [3:0] ph4, ph2, ph16;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  acc_diff_decimator #(.WIDTH(8), .RATE(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x),
    .y(y4), .y_valid(yv4), .phase(ph4));
  acc_diff_decimator #(.WIDTH(8), .RATE(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x),
    .y(y2), .y_valid(yv2), .phase(ph2));
  acc_diff_decimator #(.WIDTH(8), .RATE(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x),
    .y(y16), .y_valid(yv16), .phase(ph16));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Present one input cycle, then sample just after the rising edge
  task automatic step(input logic v, input logic [7:0] xv);
    in_valid = v;
    x        = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Four accepted samples; only the last one is a keep and must pulse
  task automatic run_block(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d,
                           input logic [7:0] exp_y, input string tag);
    step(1'b1, a); chk({tag, "_vld0"}, yv4, 0);
    step(1'b1, b); chk({tag, "_vld1"}, yv4, 0);
    step(1'b1, c); chk({tag, "_vld2"}, yv4, 0);
    step(1'b1, d); chk({tag, "_vld3"}, yv4, 1);
    chk({tag, "_y"}, y4, exp_y);
  endtask

  initial begin
    int         last_pulse;
    logic [7:0] exp_y;
    int         n;
    logic [7:0] xx;
    logic [7:0] inc;
    logic [7:0] win2, win16;
    logic       v;
    logic       exp_v;

    reset = 1'b1; in_valid = 1'b0; x = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", y4, 0);
    chk("rst_vld", yv4, 0);
    chk("rst_phase", ph4, 0);
    chk("rst_xprev", dut4.x_prev, 0);
    reset = 1'b0;

    // Priming: 3,6,9,12
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 8'(3 * i));
      chk("prime_vld", yv4, 0);
      chk("prime_phase", ph4, i % 4);
    end
    chk("prime_xprev", dut4.x_prev, 12);
    chk("prime_y", y4, 0);

    // Steady state: ramp 15..48, pulses after 24, 36, 48
    last_pulse = -1;
    for (int xv = 15; xv <= 48; xv += 3) begin
      step(1'b1, 8'(xv));
      chk("steady_vld", yv4, (xv % 12 == 0) ? 1 : 0);
      if (yv4) begin
        chk("steady_y", y4, 12);
        if (last_pulse >= 0) chk("steady_spacing", cyc - last_pulse, 4);
        last_pulse = cyc;
      end
    end

    // Wrap-around: kept 48 -> 250 -> 22 -> 2
    run_block(8'd229, 8'd236, 8'd243, 8'd250, 8'd202, "wrap_pre");
    run_block(8'd1,   8'd8,   8'd15,  8'd22,  8'd28,  "wrap_pos");
    run_block(8'd17,  8'd12,  8'd7,   8'd2,   8'hEC,  "wrap_neg");

    // Gaps: same ramp with 3 idle cycles (garbage x) after every sample
    pulse_reset();
    exp_y = 8'd0;
    for (int xv = 3; xv <= 48; xv += 3) begin
      step(1'b1, 8'(xv));
      exp_v = (xv % 12 == 0) && (xv > 12);
      if (exp_v) exp_y = 8'd12;
      chk("gap_vld", yv4, exp_v);
      chk("gap_y", y4, exp_y);
      for (int g = 0; g < 3; g++) begin
        step(1'b0, 8'hAA);
        chk("gap_idle_vld", yv4, 0);
        chk("gap_idle_phase", ph4, (xv / 3) % 4);
        chk("gap_idle_y", y4, exp_y);
      end
    end

    // Reset mid-operation at phase 2 in RUN, checked between clock edges
    step(1'b1, 8'd51);
    step(1'b1, 8'd54);
    chk("mid_phase_before", ph4, 2);
    chk("mid_y_before", y4, 12);
    #2 reset = 1'b1;
    #1;
    chk("mid_async_y", y4, 0);
    chk("mid_async_vld", yv4, 0);
    chk("mid_async_phase", ph4, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int xv = 3; xv <= 24; xv += 3) begin
      step(1'b1, 8'(xv));
      chk("mid_resume_vld", yv4, (xv == 24) ? 1 : 0);
    end
    chk("mid_resume_y", y4, 12);
    // A pulse in flight is cut by reset
    #2 reset = 1'b1;
    #1;
    chk("cut_vld", yv4, 0);
    chk("cut_y", y4, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Sweep: RATE=2 and RATE=16 with random increments and random gaps
    n = 0; xx = 8'd0; win2 = 8'd0; win16 = 8'd0;
    for (int c = 0; c < 600; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      inc = 8'($urandom_range(0, 255));
      if (v) xx = xx + inc;
      step(v, v ? xx : 8'h55);
      if (v) begin
        n++;
        win2  = win2 + inc;
        win16 = win16 + inc;
      end
      exp_v = v && (n % 2 == 0) && (n > 2);
      chk("sw2_vld", yv2, exp_v);
      if (exp_v) chk("sw2_y", y2, win2);
      chk("sw2_phase", ph2, n % 2);
      if (v && (n % 2 == 0)) win2 = 8'd0;
      exp_v = v && (n % 16 == 0) && (n > 16);
      chk("sw16_vld", yv16, exp_v);
      if (exp_v) chk("sw16_y", y16, win16);
      chk("sw16_phase", ph16, n % 16);
      if (v && (n % 16 == 0)) win16 = 8'd0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_diff_decimator.md
# acc_diff_decimator

Differencing decimator that recovers block sums from a free-running accumulator stream. It consumes the modular running sum `x` produced by an accumulating stage (s = s + b, wrapping at 2^WIDTH) and keeps every RATE-th accepted sample. For each kept sample it outputs the modular difference against the previously kept sample, which is the sum of the last RATE input increments. It is the comb/differentiator end of the integrator path, used ahead of lower-rate processing.

## Interface
- `WIDTH`, 8: bit width of `x`, `y` and all internal data registers.
- `RATE`, 4: decimation factor, legal range 2..16.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset; clears all state immediately.
- `in_valid`  input  1  `x` holds a new accumulator sample this cycle.
- `x`  input  WIDTH  running sum from the upstream accumulator (two's complement, modular).
- `y`  output  WIDTH  registered block sum; holds its value between updates.
- `y_valid`  output  1  one-cycle pulse; `y` is new this cycle.
- `phase`  output  4  accepted-sample counter, 0..RATE-1.

## Operation
- Reset values: `y` = 0, `y_valid` = 0, `phase` = 0, `x_prev` (internal) = 0, FSM = PRIME.
- Counter:
  - Advances by 1 only on cycles with `in_valid` = 1.
  - Wraps from RATE-1 to 0.
  - Holds its value while `in_valid` = 0; gaps of any length are legal.
- Keep event: `in_valid` = 1 and `phase` = RATE-1. Every RATE-th accepted sample is kept, starting with the RATE-th after reset.
- FSM, two states:
  - PRIME:
    - On a keep event: `x_prev` <= `x`, go to RUN.
    - No `y_valid` pulse and `y` is unchanged, because no valid reference exists yet.
  - RUN:
    - On a keep event: `y` <= `x` - `x_prev` mod 2^WIDTH, `x_prev` <= `x`, `y_valid` <= 1.
    - Stays in RUN.
  - No other transitions. Only `reset` returns the FSM to PRIME.
- Arithmetic:
  - Subtraction is WIDTH bits wide and the borrow is discarded.
  - `y` equals the true block sum whenever that sum lies in the signed range −2^(WIDTH−1)..2^(WIDTH−1)−1.
  - Wrap-around of `x` between two kept samples is therefore transparent.
  - No saturation and no overflow flag.
- Non-keep accepted samples update only `phase`.

## Timing
- Latency: `y` and `y_valid` update on the same rising edge that samples the keep event, so they are visible in the cycle after `in_valid` is high.
- `y_valid` is high for exactly one cycle per keep event in RUN. Back-to-back keep events at RATE cycles apart give pulses exactly RATE cycles apart.
- Throughput: one `x` per clock; no backpressure and no ready signal.
- Reset mid-operation:
  - Takes effect asynchronously.
  - A `y_valid` pulse in progress is cut.
  - The first keep after reset re-primes and produces no output.
- `reset` deassertion is assumed synchronous to `clk` externally.
- `in_valid` = 1 in the first cycle after reset release is accepted normally.

## Test plan
- Priming:
  - Stimulus: RATE=4; reset; then `x` = 3,6,9,12 with `in_valid` = 1 every cycle.
  - Required response: no `y_valid` during priming; `phase` steps 0,1,2,3,0; after priming `x_prev` = 12 and `y` = 0.
- Steady state:
  - Stimulus: continue the same ramp, `x` = 15..48 (constant increment 3).
  - Required response: `y_valid` pulses after `x` = 24, 36 and 48, each with `y` = 12; pulses are 4 cycles apart.
- Wrap-around:
  - Stimulus: WIDTH=8, increment 7, kept samples `x` = 250 then 22 (mod 256).
  - Required response: `y` = 28.
  - Stimulus: negative increment −5.
  - Required response: `y` = 0xEC (−20).
- Gaps:
  - Stimulus: same ramp, but `in_valid` low for 3 cycles between accepted samples.
  - Required response: `phase` holds during gaps; `y` values are identical to the gapless run; `y_valid` comes only after the 4th accepted sample.
- Reset mid-operation:
  - Stimulus: assert `reset` when `phase` = 2 in RUN.
  - Required response: all outputs go to 0 immediately, without waiting for a clock edge; the next 4 accepted samples produce no `y_valid`; normal pulses resume afterwards.
- Parameter sweep:
  - Stimulus: RATE = 2 and RATE = 16 with random increments.
  - Required response: every `y` equals the sum of the last RATE increments mod 2^WIDTH; pulse spacing equals RATE accepted samples.
